// File: rtl/maze_timer.sv
// ============================================================================
//  Module   : maze_timer
//  Brief    : Game elapsed-time engine; 1 s prescaler, seconds counter, and
//             progress-bar update handshake toward vga_frame.
//  Options  : MAZE_TIMER_PAUSE_EN adds i_pause and a PAUSE state.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module maze_timer #(
    parameter int CLK_HZ       = 25_000_000,
    parameter int SECS_PER_SEG = 3,
    parameter int GAME_SECS    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_stop,
`ifdef MAZE_TIMER_PAUSE_EN
    input  logic       i_pause,
`endif
    input  logic [4:0] i_painted,
    output logic       o_update_bar,
    output logic [5:0] o_seconds,
    output logic       o_running,
    output logic       o_timeout
);

    localparam int          SEG_W        = (SECS_PER_SEG < 2) ? 1 : $clog2(SECS_PER_SEG);
    localparam logic [31:0] c_PRESC_LAST = 32'(CLK_HZ - 1);
    localparam logic [SEG_W-1:0] c_SEG_LAST = SEG_W'(SECS_PER_SEG - 1);
    localparam logic [5:0]  c_GAME_SECS  = 6'(GAME_SECS);

`ifdef MAZE_TIMER_PAUSE_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DONE    = 3'd2,
        S_EXPIRED = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;
`endif

    state_t           r_state;
    logic [31:0]      r_presc;
    logic [SEG_W-1:0] r_seg_cnt;
    logic [2:0]       r_pending;
    logic             r_waiting;
    logic [4:0]       r_exp;

    state_t     w_state_nxt;
    logic       w_pause_req;
    logic       w_in_run;
    logic       w_expired;
    logic       w_advance;
    logic       w_sec_tick;
    logic       w_seg_wrap;
    logic       w_issue;
    logic       w_nxt_active;
    logic [2:0] w_pend_nxt;

`ifdef MAZE_TIMER_PAUSE_EN
    assign w_pause_req = i_pause;
`else
    assign w_pause_req = 1'b0;
`endif

    // Once the final second has landed the counter stops; EXPIRED follows next edge.
    assign w_in_run   = (r_state == S_RUN);
    assign w_expired  = (o_seconds >= c_GAME_SECS);
    assign w_advance  = w_in_run && !w_pause_req && !w_expired;
    assign w_sec_tick = w_advance && (r_presc == c_PRESC_LAST);
    assign w_seg_wrap = w_sec_tick && (r_seg_cnt == c_SEG_LAST);
    assign w_issue    = w_in_run && !i_start && (r_pending != 3'd0) && !r_waiting;

    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_stop)
                        w_state_nxt = S_DONE;
                    else if (w_expired)
                        w_state_nxt = S_EXPIRED;
`ifdef MAZE_TIMER_PAUSE_EN
                    else if (w_pause_req)
                        w_state_nxt = S_PAUSE;
`endif
                end
`ifdef MAZE_TIMER_PAUSE_EN
                S_PAUSE: begin
                    if (i_stop)
                        w_state_nxt = S_DONE;
                    else if (w_pause_req)
                        w_state_nxt = S_RUN;
                end
`endif
                default: w_state_nxt = r_state;
            endcase
        end
    end

`ifdef MAZE_TIMER_PAUSE_EN
    assign w_nxt_active = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
`else
    assign w_nxt_active = (w_state_nxt == S_RUN);
`endif

    // A simultaneous segment wrap and pulse issue leave pending unchanged.
    always_comb begin
        w_pend_nxt = r_pending;
        if (i_start || !w_nxt_active) begin
            w_pend_nxt = 3'd0;
        end else if (w_seg_wrap && !w_issue) begin
            if (r_pending != 3'd7)
                w_pend_nxt = r_pending + 3'd1;
        end else if (!w_seg_wrap && w_issue) begin
            w_pend_nxt = r_pending - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_presc      <= 32'd0;
            r_seg_cnt    <= '0;
            r_pending    <= 3'd0;
            r_waiting    <= 1'b0;
            r_exp        <= 5'd0;
            o_update_bar <= 1'b0;
            o_seconds    <= 6'd0;
            o_running    <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            o_running    <= (w_state_nxt == S_RUN);
            o_timeout    <= (w_state_nxt == S_EXPIRED);
            r_pending    <= w_pend_nxt;
            o_update_bar <= w_issue;

            if (i_start) begin
                r_presc   <= 32'd0;
                r_seg_cnt <= '0;
                o_seconds <= 6'd0;
            end else begin
                if (w_advance)
                    r_presc <= (r_presc == c_PRESC_LAST) ? 32'd0 : r_presc + 32'd1;
                if (w_sec_tick) begin
                    if (o_seconds != 6'd63)
                        o_seconds <= o_seconds + 6'd1;
                    r_seg_cnt <= w_seg_wrap ? '0 : r_seg_cnt + SEG_W'(1);
                end
            end

            // The wait for vga_frame's ack survives leaving RUN.
            if (w_issue) begin
                r_waiting <= 1'b1;
                r_exp     <= i_painted + 5'd1;
            end else if (r_waiting && (i_painted == r_exp)) begin
                r_waiting <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maze_timer.sv
// ============================================================================
//  Module   : tb_maze_timer
//  Brief    : Directed self-checking bench for maze_timer with a vga_frame
//             ack model (acks 3 cycles after each pulse).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_maze_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
`ifdef MAZE_TIMER_PAUSE_EN
    logic       i_pause = 1'b0;
`endif
    logic [4:0] painted = 5'd0;
    logic       o_update_bar;
    logic [5:0] o_seconds;
    logic       o_running;
    logic       o_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int ack_dly = 0;
    bit ack_hold = 1'b0;
    int base_p;
    int base_painted;

    maze_timer #(
        .CLK_HZ       (10),
        .SECS_PER_SEG (2),
        .GAME_SECS    (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
`ifdef MAZE_TIMER_PAUSE_EN
        .i_pause      (i_pause),
`endif
        .i_painted    (painted),
        .o_update_bar (o_update_bar),
        .o_seconds    (o_seconds),
        .o_running    (o_running),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    // vga_frame stand-in: paints one segment 3 cycles after each request.
    always @(negedge clk) begin
        if (o_update_bar) begin
            pulses  = pulses + 1;
            ack_dly = 3;
        end else if (ack_dly > 1) begin
            ack_dly = ack_dly - 1;
        end else if (ack_dly == 1 && !ack_hold) begin
            painted = painted + 5'd1;
            ack_dly = 0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Leaves the bench 2 ns after the edge that sampled i_start (edge E0).
    task automatic start_game();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_seconds", o_seconds, 0);
        chk("rst_running", o_running, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_update",  o_update_bar, 0);
        tick(50);
        chk("idle_pulses",  pulses, 0);
        chk("idle_seconds", o_seconds, 0);

        // First game: timing of seconds and first pulse
        start_game();
        chk("run_after_start", o_running, 1);
        tick(9);
        chk("sec_e9", o_seconds, 0);
        tick(1);
        chk("sec_e10", o_seconds, 1);
        tick(10);
        chk("sec_e20", o_seconds, 2);
        chk("no_pulse_e20", o_update_bar, 0);
        tick(1);
        chk("pulse_e21", o_update_bar, 1);
        tick(1);
        chk("pulse_one_cycle", o_update_bar, 0);
        chk("pulse_count_1", pulses, 1);

        // Run to expiry
        tick(38);
        chk("sec_e60", o_seconds, 6);
        chk("run_e60", o_running, 1);
        chk("tmo_e60", o_timeout, 0);
        tick(1);
        chk("tmo_e61", o_timeout, 1);
        chk("run_e61", o_running, 0);
        chk("pulse_e61", o_update_bar, 1);
        tick(25);
        chk("end_pulses", pulses, 3);
        chk("end_painted", painted, 3);
        chk("end_seconds", o_seconds, 6);

        // Ack withheld: queued segment waits for the ack
        ack_hold = 1'b1;
        base_p = pulses;
        start_game();
        tick(40);
        chk("hold_sec_e40", o_seconds, 4);
        chk("hold_no_2nd_e40", pulses - base_p, 1);
        tick(10);
        chk("hold_no_2nd_e50", pulses - base_p, 1);
        ack_hold = 1'b0;
        tick(1);
        chk("hold_e51_quiet", o_update_bar, 0);
        tick(1);
        chk("hold_e52_pulse", o_update_bar, 1);
        tick(14);
        chk("hold_e66_tmo", o_timeout, 1);
        tick(10);
        chk("hold_total", pulses - base_p, 3);
        chk("hold_painted", painted, 6);

        // Stop on the final tick
        base_p = pulses;
        start_game();
        tick(59);
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        chk("stop_sec", o_seconds, 6);
        chk("stop_run", o_running, 0);
        chk("stop_tmo", o_timeout, 0);
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        tick(20);
        chk("done_hold_sec", o_seconds, 6);
        chk("done_tmo", o_timeout, 0);
        chk("done_pulses", pulses - base_p, 2);
        start_game();
        chk("restart_sec", o_seconds, 0);
        chk("restart_run", o_running, 1);

        // Reset mid-game
        tick(25);
        chk("mid_sec", o_seconds, 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_sec", o_seconds, 0);
        chk("midrst_run", o_running, 0);
        chk("midrst_upd", o_update_bar, 0);
        tick(20);
        chk("midrst_idle_sec", o_seconds, 0);

`ifdef MAZE_TIMER_PAUSE_EN
        // Pause at prescaler=4, resume, tick 6 cycles later
        tick(10);
        base_p = pulses;
        start_game();
        tick(4);
        i_pause = 1'b1;
        tick(1);
        i_pause = 1'b0;
        chk("pause_run", o_running, 0);
        tick(30);
        chk("pause_sec", o_seconds, 0);
        chk("pause_pulses", pulses - base_p, 0);
        i_pause = 1'b1;
        tick(1);
        i_pause = 1'b0;
        chk("resume_run", o_running, 1);
        tick(5);
        chk("resume_sec_5", o_seconds, 0);
        tick(1);
        chk("resume_sec_6", o_seconds, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
